modadd_seq: RTL and testbench
=============================

# modadd_seq

Sequential modular add/subtract controller for the RSA datapath. It computes r = (a + b) mod m or r = (a − b) mod m by issuing one or two operations to the multi-precision adder over its start/subtract/result/done interface. It is the initiator side of that interface: it drives operands and `start`, then consumes `result` and `done`. It sits between the exponentiation sequencer and the shared adder, so the sequencer never handles carries or borrows directly.

## Interface
- `W`, 1027: operand width in bits. Adder result width is `W+1`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request. Sampled only in IDLE.
- `subtract` input 1: 0 selects a+b, 1 selects a−b. Captured with `start`.
- `in_a`, `in_b`, `in_m` input W: operands and modulus. Captured with `start`. Caller guarantees a, b < m < 2^(W−1).
- `busy` output 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` output 1: one-cycle pulse when the result is valid.
- `result` output W: modular result. Held from `done` until the next accepted `start`.
- `add_start` output 1: one-cycle pulse to the adder.
- `add_subtract` output 1: adder mode.
- `add_a`, `add_b` output W: adder operands. Stable from `add_start` until `add_done`.
- `add_result` input W+1: adder output. In subtract mode, bit W = 1 means borrow (negative).
- `add_done` input 1: adder completion. Arrives L ≥ 1 cycles after `add_start`.

## Operation
- States: IDLE → ISSUE1 → WAIT1 → ISSUE2 → WAIT2 → DONE → IDLE.
- IDLE with `start`=1: register a, b, m and `subtract`, then go to ISSUE1.
- ISSUE1: pulse `add_start`. Drive a and b, with `add_subtract` = `subtract`. Go to WAIT1.
- WAIT1 on `add_done`: store t = `add_result[W-1:0]` and the borrow flag = `add_result[W]`.
- Add path:
  - ISSUE2 issues t − m (`add_subtract`=1).
  - In WAIT2, if `add_result[W]`=1 then r = t; otherwise r = `add_result[W-1:0]`.
- Subtract path:
  - ISSUE2 issues t + m (`add_subtract`=0).
  - If the borrow flag was set, r = `add_result[W-1:0]`; otherwise r = t.
- Without `MODADD_CONST_TIME_EN`: on the subtract path with borrow = 0, WAIT1 goes directly to DONE with r = t, and ISSUE2 is skipped.
- DONE: register r into `result` and pulse `done`, then go to IDLE.
- Boundary rules:
  - `start` while `busy`: ignored. Captured operands do not change.
  - `add_done` outside WAIT1/WAIT2: ignored.
  - `add_done` in the same cycle as `add_start`: not possible, since L ≥ 1. The bench checks this.
  - `reset` mid-operation: immediate return to IDLE. `add_start`, `busy`, `done` go to 0 and `result` is cleared. A pending adder `add_done` arriving after reset is ignored.
  - a = b in subtract mode: r = 0 with no borrow.
  - Add path result t − m = 0: no borrow, so r = 0.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `add_start`=0, `add_subtract`=0, `add_a`=0, `add_b`=0, state = IDLE.
- `start` is sampled at edge 0. `add_start` is high in cycle 1. `add_done` arrives in cycle 1+L. The second `add_start` is high in cycle 2+L.
- Full path: `done` is high in cycle 3+2L.
- Short path (no const-time, subtract, no borrow): `done` is high in cycle 2+L.
- The earliest next `start` is accepted in the cycle after `done`.
- All outputs are registered. There is no combinational path from `add_done` or `add_result` to any output.

## Configuration
- `MODADD_CONST_TIME_EN` defined: both paths always perform two adder operations, and latency is always 3+2L. This is the side-channel-hardened build. The unneeded t + m result is discarded.
- `MODADD_CONST_TIME_EN` undefined: subtract without borrow finishes after one operation. Latency depends on the data.

## Structure
- `modadd_pkg`: parameter `W`, the state enum (IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE), and the borrow-bit index constant `W`.
- One sub-module, `modadd_opsel`: combinational selection of ISSUE2 operands and the final r, from state, mode, t and borrow. The FSM and registers stay in the top.
- The adder itself is external, connected through the `add_*` ports.

## Test plan
The bench uses W=8, m=101, and an adder model with L=3.
- Add 60 + 70: `result`=29, `done` in cycle 9, two `add_start` pulses.
- Add 100 + 100: `result`=99. Add 0 + 0: `result`=0, with the t − m borrow taken.
- Subtract 20 − 30: `result`=91, two operations, `done` in cycle 9.
- Subtract 30 − 20: `result`=10.
  - With the macro: `done` in cycle 9.
  - Without the macro: `done` in cycle 5, one `add_start` only.
- `start` pulsed during WAIT1 with different operands: ignored, and the original result is returned.
- `reset` asserted in WAIT2, then a late `add_done`: all outputs 0, state IDLE, no `done` pulse. A following add 1 + 1 returns 2.

Source files
------------

// File: rtl/modadd_pkg.sv
// modadd_pkg: shared definitions for the sequential modular add/subtract
// controller (modadd_seq) and its operand-select helper (modadd_opsel).
//   MODADD_W : default operand width; the adder result is MODADD_W+1 bits
//              and bit MODADD_W carries the borrow in subtract mode.
//   state_t  : controller FSM states.
package modadd_pkg;

  localparam int unsigned MODADD_W = 1027;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    ISSUE2,
    WAIT2,
    DONE
  } state_t;

endpackage

// File: rtl/modadd_opsel.sv
// modadd_opsel: combinational selection of the second adder operation's
// operands and of the final modular result r.
// Ports:
//   i_state      : controller state
//   i_subtract   : captured mode (0 = a+b, 1 = a-b)
//   i_t          : stored first-operation result t
//   i_borrow     : stored borrow flag of the first operation
//   i_m          : captured modulus
//   i_add_result : live adder result (W+1 bits, bit W = carry/borrow)
//   o_op_a/o_op_b/o_op_sub : operands and mode for the second operation
//   o_r          : modular result to be registered when the operation ends
module modadd_opsel
  import modadd_pkg::*;
#(
  parameter int unsigned W = MODADD_W
) (
  input  state_t       i_state,
  input  logic         i_subtract,
  input  logic [W-1:0] i_t,
  input  logic         i_borrow,
  input  logic [W-1:0] i_m,
  input  logic [W:0]   i_add_result,
  output logic [W-1:0] o_op_a,
  output logic [W-1:0] o_op_b,
  output logic         o_op_sub,
  output logic [W-1:0] o_r
);

  always_comb begin
    // Second operands are loaded on the WAIT1 -> ISSUE2 edge, when t is
    // still only visible on the adder result bus.
    o_op_a   = i_add_result[W-1:0];
    o_op_b   = i_m;
    o_op_sub = ~i_subtract;

    if (i_state == WAIT1) begin
      // Short subtract path: no borrow, result is t straight from the adder.
      o_r = i_add_result[W-1:0];
    end else if (!i_subtract) begin
      // t - m borrowed: t was already reduced.
      o_r = i_add_result[W] ? i_t : i_add_result[W-1:0];
    end else begin
      // Negative difference needs the +m correction; otherwise discard it.
      o_r = i_borrow ? i_add_result[W-1:0] : i_t;
    end
  end

endmodule

// File: rtl/modadd_seq.sv
// modadd_seq: sequential modular add/subtract controller. Computes
// (a + b) mod m or (a - b) mod m using one or two operations on an
// external multi-precision adder.
// Build option: MODADD_CONST_TIME_EN forces two adder operations on every
// path (data-independent latency).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start, subtract     : request and mode, sampled in IDLE
//   in_a, in_b, in_m    : operands and modulus, captured with start
//   busy, done, result  : status, one-cycle completion pulse, held result
//   add_start, add_subtract, add_a, add_b : adder request side
//   add_result, add_done                  : adder response side
module modadd_seq
  import modadd_pkg::*;
#(
  parameter int unsigned W = MODADD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         subtract,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         add_start,
  output logic         add_subtract,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W:0]   add_result,
  input  logic         add_done
);

  localparam int unsigned BORROW = W;

  state_t       r_state;
  state_t       w_next;
  logic         r_sub;
  logic [W-1:0] r_m;
  logic [W-1:0] r_t;
  logic         r_borrow;

  logic         w_busy;
  logic         w_done;
  logic         w_add_start;
  logic         w_accept;
  logic         w_capture_t;

  logic [W-1:0] w_op_a;
  logic [W-1:0] w_op_b;
  logic         w_op_sub;
  logic [W-1:0] w_r;

  modadd_opsel #(.W(W)) u_opsel (
    .i_state      (r_state),
    .i_subtract   (r_sub),
    .i_t          (r_t),
    .i_borrow     (r_borrow),
    .i_m          (r_m),
    .i_add_result (add_result),
    .o_op_a       (w_op_a),
    .o_op_b       (w_op_b),
    .o_op_sub     (w_op_sub),
    .o_r          (w_r)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (start) w_next = ISSUE1;
      ISSUE1: w_next = WAIT1;
      WAIT1: begin
        if (add_done) begin
          if (r_sub && !add_result[BORROW]) begin
`ifdef MODADD_CONST_TIME_EN
            w_next = ISSUE2;
`else
            w_next = DONE;
`endif
          end else begin
            w_next = ISSUE2;
          end
        end
      end
      ISSUE2: w_next = WAIT2;
      WAIT2:  if (add_done) w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode; every output is registered from the next state so
  // nothing on the adder response side reaches an output combinationally.
  always_comb begin
    w_busy      = (w_next != IDLE);
    w_done      = (w_next == DONE);
    w_add_start = (w_next == ISSUE1) || (w_next == ISSUE2);
    w_accept    = (r_state == IDLE) && start;
    w_capture_t = (r_state == WAIT1) && add_done;
  end

  // a and b are captured straight into the adder operand registers; they
  // are only needed for the first operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
      r_sub        <= 1'b0;
      r_m          <= '0;
      r_t          <= '0;
      r_borrow     <= 1'b0;
    end else begin
      busy      <= w_busy;
      done      <= w_done;
      add_start <= w_add_start;

      if (w_accept) begin
        r_sub        <= subtract;
        r_m          <= in_m;
        add_a        <= in_a;
        add_b        <= in_b;
        add_subtract <= subtract;
      end

      if (w_capture_t) begin
        r_t      <= add_result[W-1:0];
        r_borrow <= add_result[BORROW];
      end

      if ((r_state == WAIT1) && (w_next == ISSUE2)) begin
        add_a        <= w_op_a;
        add_b        <= w_op_b;
        add_subtract <= w_op_sub;
      end

      if (w_done) result <= w_r;
    end
  end

endmodule

// File: tb/tb_modadd_seq.sv
module tb_modadd_seq;
  import modadd_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned M = 101;
  localparam int unsigned L = 3;

`ifdef MODADD_CONST_TIME_EN
  localparam int SHORT_LAT = 9;
  localparam int SHORT_NST = 2;
`else
  localparam int SHORT_LAT = 5;
  localparam int SHORT_NST = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         subtract;
  logic [W-1:0] in_a, in_b, in_m;
  logic         busy, done;
  logic [W-1:0] result;
  logic         add_start, add_subtract;
  logic [W-1:0] add_a, add_b;
  logic [W:0]   add_result;
  logic         add_done;

  modadd_seq #(.W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .subtract     (subtract),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_add_start = 0;
  int rst_epoch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r;
    int           lat;
    int           nst;
    int           t0;
    int           s0;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Adder model: latency L, result sampled at negedge, add_done for one cycle.
  initial begin : adder_model
    logic [W-1:0] la, lb;
    logic         ls;
    int           ep;
    add_done   = 1'b0;
    add_result = '0;
    forever begin
      @(negedge clk);
      add_done = 1'b0;
      if (add_start === 1'b1) begin
        n_add_start++;
        la = add_a;
        lb = add_b;
        ls = add_subtract;
        ep = rst_epoch;
        repeat (L) @(negedge clk);
        chk("no_add_start_with_add_done", {31'b0, add_start}, 32'd0);
        if (ep == rst_epoch) begin
          chk("add_a_stable", {24'b0, add_a}, {24'b0, la});
          chk("add_b_stable", {24'b0, add_b}, {24'b0, lb});
        end
        add_result = ls ? ({1'b0, la} - {1'b0, lb}) : ({1'b0, la} + {1'b0, lb});
        add_done = 1'b1;
      end
    end
  end

  // Monitor: pops an expectation for every done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", {31'b0, done}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("result", {24'b0, result}, {24'b0, e.r});
          chk("done_latency", cyc - e.t0, e.lat);
          chk("add_start_count", n_add_start - e.s0, e.nst);
          chk("busy_at_done", {31'b0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic issue(input int a, input int b, input logic sub, input logic push,
                       input int exp_r, input int exp_lat, input int exp_nst);
    exp_t e;
    @(negedge clk);
    in_a     = W'(a);
    in_b     = W'(b);
    in_m     = W'(M);
    subtract = sub;
    start    = 1'b1;
    if (push) begin
      e.r   = W'(exp_r);
      e.lat = exp_lat;
      e.nst = exp_nst;
      e.t0  = cyc;
      e.s0  = n_add_start;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int exp_r);
    int k = 0;
    while (sbq.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_60_cycles");
      sbq.delete();
    end
    repeat (3) @(negedge clk);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
    chk("result_held", {24'b0, result}, exp_r);
  endtask

  task automatic run(input int a, input int b, input logic sub,
                     input int exp_r, input int exp_lat, input int exp_nst);
    issue(a, b, sub, 1'b1, exp_r, exp_lat, exp_nst);
    wait_idle(exp_r);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    subtract = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_m     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", {24'b0, result}, 32'd0);
    chk("rst_add_start", {31'b0, add_start}, 32'd0);
    chk("rst_add_subtract", {31'b0, add_subtract}, 32'd0);
    chk("rst_add_a", {24'b0, add_a}, 32'd0);
    chk("rst_add_b", {24'b0, add_b}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run(60, 70, 1'b0, 29, 9, 2);
    run(100, 100, 1'b0, 99, 9, 2);
    run(0, 0, 1'b0, 0, 9, 2);
    run(41, 60, 1'b0, 0, 9, 2);
    run(20, 30, 1'b1, 91, 9, 2);
    run(30, 20, 1'b1, 10, SHORT_LAT, SHORT_NST);
    run(50, 50, 1'b1, 0, SHORT_LAT, SHORT_NST);
    run(0, 100, 1'b1, 1, 9, 2);

    // start during WAIT1 must be ignored
    issue(60, 70, 1'b0, 1'b1, 29, 9, 2);
    @(negedge clk);
    in_a     = 8'd10;
    in_b     = 8'd20;
    subtract = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(29);

    // reset in WAIT2, late add_done must be ignored
    issue(60, 70, 1'b0, 1'b0, 0, 0, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    rst_epoch++;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", {24'b0, result}, 32'd0);
    chk("abort_add_start", {31'b0, add_start}, 32'd0);
    chk("abort_add_a", {24'b0, add_a}, 32'd0);
    chk("abort_add_b", {24'b0, add_b}, 32'd0);
    chk("abort_add_subtract", {31'b0, add_subtract}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_state_idle", 32'(dut.r_state), 32'(IDLE));
    chk("abort_busy_after_late_done", {31'b0, busy}, 32'd0);
    chk("abort_result_after_late_done", {24'b0, result}, 32'd0);

    run(1, 1, 1'b0, 2, 9, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
